// File: rtl/pc_fetch_pkg.sv
// Shared types and constants for the pc_fetch_queue fetch stage.
package pc_fetch_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [0:0] {
    FETCH = 1'b0,
    DRAIN = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
  } fetch_entry_t;

  // Sequential instruction address, wrapping modulo 2^32.
  function automatic logic [31:0] next_pc(input logic [31:0] addr);
    return addr + 32'd4;
  endfunction

endpackage

// File: rtl/pc_fetch_queue_if.sv
// Instruction-memory request/response bus and decoded-instruction output handshake.
interface pc_fetch_queue_if;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic [31:0] inst_pc;
  logic [31:0] inst_data;
  logic        inst_ready;

  modport master (
    output imem_req, imem_addr, inst_valid, inst_pc, inst_data,
    input  imem_gnt, imem_rvalid, imem_rdata, inst_ready
  );

  modport slave (
    input  imem_req, imem_addr, inst_valid, inst_pc, inst_data,
    output imem_gnt, imem_rvalid, imem_rdata, inst_ready
  );

endinterface

// File: rtl/fetch_fifo.sv
// In-order queue of fetched {pc, data} entries with flush and occupancy count.
module fetch_fifo
  import pc_fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          push,
  input  logic          pop,
  input  fetch_entry_t  wr_entry,
  output fetch_entry_t  rd_entry,
  output logic [CW-1:0] count
);

  fetch_entry_t  mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;

  // Storage, pointers and occupancy; the array is cleared so the head reads zero out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else if (flush) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push) begin
        mem_r[wr_ptr_r] <= wr_entry;
        wr_ptr_r        <= wr_ptr_r + AW'(1'b1);
      end
      if (pop) begin
        rd_ptr_r <= rd_ptr_r + AW'(1'b1);
      end
      case ({push, pop})
        2'b10:   count_r <= count_r + CW'(1'b1);
        2'b01:   count_r <= count_r - CW'(1'b1);
        default: count_r <= count_r;
      endcase
    end
  end

  assign rd_entry = mem_r[rd_ptr_r];
  assign count    = count_r;

endmodule

// File: rtl/pc_fetch_queue.sv
// Fetch stage: pipelined instruction-memory requests, in-order return queue, redirect flush.
// Define FETCH_ALIGN_CHK_EN to flag misaligned redirect targets on fetch_err.
module pc_fetch_queue
  import pc_fetch_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      pc_in,
  input  logic             redirect,
  pc_fetch_queue_if.master bus,
  output logic             fetch_err
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int SW = CW + 1;

  fetch_state_e  state_r, state_nxt_s;
  logic [31:0]   fetch_addr_r, fetch_addr_nxt_s;
  logic [31:0]   resp_pc_r, resp_pc_nxt_s;
  logic [31:0]   target_s;
  logic [CW-1:0] occ_s, occ_nxt_s;
  logic [CW-1:0] outst_r, outst_nxt_s;
  logic [CW-1:0] kill_r, kill_nxt_s;
  logic          req_r, req_nxt_s;
  logic          valid_r;
  logic          err_r, err_nxt_s;
  logic          grant_s, push_s, pop_s;
  fetch_entry_t  wr_entry_s, head_s;

  assign grant_s    = req_r & bus.imem_gnt;
  assign push_s     = (state_r == FETCH) & bus.imem_rvalid & ~redirect;
  assign pop_s      = valid_r & bus.inst_ready & ~redirect;
  assign wr_entry_s = {resp_pc_r, bus.imem_rdata};
  assign target_s   = {pc_in[31:2], 2'b00};

`ifdef FETCH_ALIGN_CHK_EN
  assign err_nxt_s = redirect ? (pc_in[1:0] != 2'b00) : err_r;
`else
  logic unused_lsb_s;
  assign unused_lsb_s = ^pc_in[1:0];
  assign err_nxt_s    = 1'b0;
`endif

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (redirect),
    .push     (push_s),
    .pop      (pop_s),
    .wr_entry (wr_entry_s),
    .rd_entry (head_s),
    .count    (occ_s)
  );

  // Next occupancy, in-flight and kill counts; kill covers everything still in flight after a redirect.
  always_comb begin
    occ_nxt_s = occ_s;
    if (redirect) begin
      occ_nxt_s = {CW{1'b0}};
    end else if (push_s && !pop_s) begin
      occ_nxt_s = occ_s + CW'(1'b1);
    end else if (pop_s && !push_s) begin
      occ_nxt_s = occ_s - CW'(1'b1);
    end else begin
      occ_nxt_s = occ_s;
    end

    case ({grant_s, bus.imem_rvalid})
      2'b10:   outst_nxt_s = outst_r + CW'(1'b1);
      2'b01:   outst_nxt_s = outst_r - CW'(1'b1);
      default: outst_nxt_s = outst_r;
    endcase

    kill_nxt_s = kill_r;
    if (redirect) begin
      kill_nxt_s = outst_nxt_s;
    end else if ((state_r == DRAIN) && bus.imem_rvalid && (kill_r != {CW{1'b0}})) begin
      kill_nxt_s = kill_r - CW'(1'b1);
    end else begin
      kill_nxt_s = kill_r;
    end
  end

  // FSM transition, address updates and the credit check for the next request.
  always_comb begin
    state_nxt_s = state_r;
    if (redirect) begin
      state_nxt_s = (kill_nxt_s != {CW{1'b0}}) ? DRAIN : FETCH;
    end else begin
      case (state_r)
        FETCH:   state_nxt_s = FETCH;
        DRAIN:   state_nxt_s = (kill_nxt_s == {CW{1'b0}}) ? FETCH : DRAIN;
        default: state_nxt_s = FETCH;
      endcase
    end

    fetch_addr_nxt_s = fetch_addr_r;
    if (redirect) begin
      fetch_addr_nxt_s = target_s;
    end else if (grant_s) begin
      fetch_addr_nxt_s = next_pc(fetch_addr_r);
    end else begin
      fetch_addr_nxt_s = fetch_addr_r;
    end

    resp_pc_nxt_s = resp_pc_r;
    if (redirect) begin
      resp_pc_nxt_s = target_s;
    end else if (push_s) begin
      resp_pc_nxt_s = next_pc(resp_pc_r);
    end else begin
      resp_pc_nxt_s = resp_pc_r;
    end

    req_nxt_s = (state_nxt_s == FETCH) && !err_nxt_s &&
                (({1'b0, occ_nxt_s} + {1'b0, outst_nxt_s}) < SW'(DEPTH));
  end

  // Control state and registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= FETCH;
      fetch_addr_r <= RESET_PC;
      resp_pc_r    <= RESET_PC;
      outst_r      <= {CW{1'b0}};
      kill_r       <= {CW{1'b0}};
      req_r        <= 1'b0;
      valid_r      <= 1'b0;
      err_r        <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      fetch_addr_r <= fetch_addr_nxt_s;
      resp_pc_r    <= resp_pc_nxt_s;
      outst_r      <= outst_nxt_s;
      kill_r       <= kill_nxt_s;
      req_r        <= req_nxt_s;
      valid_r      <= (occ_nxt_s != {CW{1'b0}});
      err_r        <= err_nxt_s;
    end
  end

  assign bus.imem_req   = req_r;
  assign bus.imem_addr  = fetch_addr_r;
  assign bus.inst_valid = valid_r;
  assign bus.inst_pc    = head_s.pc;
  assign bus.inst_data  = head_s.data;
  assign fetch_err      = err_r;

endmodule

// File: tb/tb_pc_fetch_queue.sv
// Scoreboard bench for pc_fetch_queue: memory model with tagged in-flight requests, expected-word queue.
module tb_pc_fetch_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] pc_in = 32'h0;
  logic        fetch_err;

  pc_fetch_queue_if bus();

  pc_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pc_in     (pc_in),
    .redirect  (redirect),
    .bus       (bus),
    .fetch_err (fetch_err)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; int epoch; int due; } req_t;
  typedef struct { logic [31:0] pc; logic [31:0] data; } exp_t;

  req_t        memq[$];
  exp_t        sb[$];
  logic [31:0] cap[$];
  int          cap_cyc[$];

  int checks = 0, failures = 0;
  int cyc = 0, cur_epoch = 0, last_due = 0, redir_cyc = 0;
  int lat = 1, lat_rand = 0, gnt_pct = 100, rdy_pct = 100, redir_pct = 0;
  int redir_req = 0, redir_both = 0;
  int n_grants = 0, n_pops = 0;
  logic [31:0] exp_fetch = 32'h0, redir_pc = 32'h0;
  logic        exp_err = 1'b0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {~a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  function automatic logic [31:0] cap_at(input int i);
    if (i < cap.size()) return cap[i];
    return 32'hDEAD_BEEF;
  endfunction

  function automatic int cap_cyc_at(input int i);
    if (i < cap_cyc.size()) return cap_cyc[i];
    return -1000;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; redirect = 1'b0; pc_in = 32'h0;
    bus.imem_gnt = 1'b0; bus.imem_rvalid = 1'b0; bus.imem_rdata = 32'h0; bus.inst_ready = 1'b0;
    memq.delete(); sb.delete(); cap.delete(); cap_cyc.delete();
    cur_epoch++; exp_fetch = 32'h0; exp_err = 1'b0; last_due = cyc;
    redir_req = 0; redir_both = 0;
    @(negedge clk);
    check("rst_imem_req", 32'(bus.imem_req), 32'h0);
    check("rst_inst_valid", 32'(bus.inst_valid), 32'h0);
    check("rst_fetch_err", 32'(fetch_err), 32'h0);
    check("rst_inst_pc", bus.inst_pc, 32'h0);
    check("rst_inst_data", bus.inst_data, 32'h0);
    rst_n = 1'b1;
  endtask

  task automatic cycle();
    int   n_live, n_stale, this_lat, due;
    logic exp_req, g, rv, rdy, redir, do_pop;
    req_t rec;
    rec = '{addr: 32'h0, epoch: -1, due: 0};
    @(negedge clk);
    n_live = 0; n_stale = 0;
    foreach (memq[i]) begin
      if (memq[i].epoch == cur_epoch) n_live++;
      else n_stale++;
    end
    exp_req = (n_stale == 0) && !exp_err && ((sb.size() + n_live) < DEPTH);
    check("imem_req", 32'(bus.imem_req), 32'(exp_req));
    check("inst_valid", 32'(bus.inst_valid), 32'(sb.size() != 0));
    check("fetch_err", 32'(fetch_err), 32'(exp_err));
    if (sb.size() != 0) begin
      check("inst_pc", bus.inst_pc, sb[0].pc);
      check("inst_data", bus.inst_data, sb[0].data);
    end

    g   = ($urandom_range(99) < gnt_pct);
    rv  = (memq.size() != 0) && (memq[0].due <= cyc);
    rdy = ($urandom_range(99) < rdy_pct);
    if (bus.inst_valid && rdy) n_pops++;
    if (redir_req == 0 && redir_pct > 0 && $urandom_range(99) < redir_pct) begin
      redir_pc = $urandom();
      if ($urandom_range(3) != 0) redir_pc[1:0] = 2'b00;
      redir_req = 1;
    end
    redir = (redir_req != 0) || ((redir_both != 0) && g && bus.imem_req && rv);

    bus.imem_gnt   = g;
    bus.inst_ready = rdy;
    redirect       = redir;
    pc_in          = redir ? redir_pc : $urandom();
    if (rv) begin
      rec = memq.pop_front();
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata  = mem_word(rec.addr);
    end else begin
      bus.imem_rvalid = 1'b0;
      bus.imem_rdata  = $urandom();
    end

    do_pop = rdy && (sb.size() != 0) && !redir;
    if (g && bus.imem_req) begin
      check("imem_addr", bus.imem_addr, exp_fetch);
      this_lat = (lat_rand != 0) ? int'($urandom_range(4, 1)) : lat;
      due = cyc + this_lat;
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      memq.push_back('{addr: exp_fetch, epoch: cur_epoch, due: due});
      cap.push_back(bus.imem_addr);
      cap_cyc.push_back(cyc);
      exp_fetch = exp_fetch + 32'd4;
      n_grants++;
    end
    if (do_pop) sb.delete(0);
    if (rv && rec.epoch == cur_epoch && !redir) sb.push_back('{pc: rec.addr, data: mem_word(rec.addr)});
    if (redir) begin
      sb.delete();
      cur_epoch++;
      exp_fetch = {redir_pc[31:2], 2'b00};
`ifdef FETCH_ALIGN_CHK_EN
      exp_err = (redir_pc[1:0] != 2'b00);
`endif
      redir_req = 0; redir_both = 0; redir_cyc = cyc;
      cap.delete(); cap_cyc.delete();
    end
    cyc++;
    @(posedge clk);
  endtask

  initial begin
    int p0, g0;
    bus.imem_gnt = 1'b0; bus.imem_rvalid = 1'b0; bus.imem_rdata = 32'h0; bus.inst_ready = 1'b0;

    // Streaming: grant every cycle, 1-cycle memory, always ready.
    lat = 1; gnt_pct = 100; rdy_pct = 100;
    do_reset();
    repeat (4) cycle();
    check("seq_req0", cap_at(0), 32'h0000_0000);
    check("seq_req1", cap_at(1), 32'h0000_0004);
    check("seq_req2", cap_at(2), 32'h0000_0008);
    p0 = n_pops;
    repeat (20) cycle();
    check("throughput", 32'(n_pops - p0), 32'd20);

    // Back-pressure: queue fills to DEPTH, then a single pop frees one credit.
    do_reset();
    rdy_pct = 0;
    g0 = n_grants;
    repeat (10) cycle();
    check("grants_to_full", 32'(n_grants - g0), 32'd4);
    #1;
    check("full_req_low", 32'(bus.imem_req), 32'h0);
    check("full_valid", 32'(bus.inst_valid), 32'h1);
    rdy_pct = 100;
    cycle();
    rdy_pct = 0;
    g0 = n_grants;
    repeat (6) cycle();
    check("one_pop_one_req", 32'(n_grants - g0), 32'd1);

    // Redirect with three requests in flight on a 3-cycle memory.
    do_reset();
    rdy_pct = 100; lat = 3;
    repeat (2) cycle();
    redir_pc = 32'h0000_0100; redir_req = 1;
    cycle();
    repeat (12) cycle();
    check("drain3_first_addr", cap_at(0), 32'h0000_0100);
    check("drain3_len", 32'(cap_cyc_at(0) - redir_cyc), 32'd4);

    // Redirect in a cycle that also carries a grant and a response.
    do_reset();
    lat = 2; redir_pc = 32'h0000_0040; redir_both = 1;
    repeat (14) cycle();
    check("both_first_addr", cap_at(0), 32'h0000_0040);
    check("both_drain_len", 32'(cap_cyc_at(0) - redir_cyc), 32'd3);

    // Address wrap at the top of the address space.
    do_reset();
    lat = 1; redir_pc = 32'hFFFF_FFF8; redir_req = 1;
    repeat (9) cycle();
    check("wrap_req0", cap_at(0), 32'hFFFF_FFF8);
    check("wrap_req1", cap_at(1), 32'hFFFF_FFFC);
    check("wrap_req2", cap_at(2), 32'h0000_0000);

    // Misaligned redirect target.
    do_reset();
    redir_pc = 32'h0000_0102; redir_req = 1;
    cycle();
    #1;
`ifdef FETCH_ALIGN_CHK_EN
    check("misalign_err_set", 32'(fetch_err), 32'h1);
    check("misalign_req_low", 32'(bus.imem_req), 32'h0);
    repeat (5) cycle();
    check("misalign_no_req", 32'(cap.size()), 32'd0);
    redir_pc = 32'h0000_0200; redir_req = 1;
    cycle();
    #1;
    check("realign_err_clr", 32'(fetch_err), 32'h0);
    repeat (6) cycle();
    check("realign_first_addr", cap_at(0), 32'h0000_0200);
`else
    check("misalign_err_tied", 32'(fetch_err), 32'h0);
    repeat (6) cycle();
    check("misalign_ignored", cap_at(0), 32'h0000_0100);
`endif

    // Random grants, latencies, ready and redirects, then a mid-run reset.
    lat_rand = 1; gnt_pct = 70; rdy_pct = 60; redir_pct = 4;
    repeat (400) cycle();
    redir_pct = 0; lat_rand = 0; lat = 1; gnt_pct = 100; rdy_pct = 100;
    do_reset();
    repeat (6) cycle();
    check("post_reset_req0", cap_at(0), 32'h0000_0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pc_fetch_queue.md
# pc_fetch_queue

Instruction fetch stage directly downstream of the PC register. Takes the PC register output as the redirect target and runs its own sequential fetch address, so it can keep several requests in flight to an instruction memory over a request/grant + response handshake. Returned words are buffered with their PCs in a DEPTH-entry in-order queue. Redirects flush the queue and discard stale in-flight responses.

## Interface
- DEPTH, 4: queue entries and the maximum requests in flight; power of 2, ≥2
- RESET_PC, 32'h0000_0000: fetch address after reset
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- pc_in  in  32  redirect target, driven by the PC register output
- redirect  in  1  flush the queue and refetch from pc_in
- imem_req  out  1  fetch request
- imem_addr  out  32  fetch address
- imem_gnt  in  1  request accepted when imem_req && imem_gnt
- imem_rvalid  in  1  one in-order response per accepted request, at least 1 cycle after grant
- imem_rdata  in  32  instruction word
- inst_valid  out  1  queue not empty
- inst_pc  out  32  PC of the head entry
- inst_data  out  32  instruction word of the head entry
- inst_ready  in  1  pop when inst_valid && inst_ready
- fetch_err  out  1  misaligned redirect flag; see Configuration

## Operation
- Counters:
  - occ (0..DEPTH): queue occupancy
  - outst (0..DEPTH): accepted requests not yet answered
  - kill (0..DEPTH): responses still to be discarded
- Addresses:
  - fetch_addr: next address to request
  - resp_pc: PC of the next response that is kept
- FSM states:
  - FETCH: imem_req = (occ + outst < DEPTH). On grant, fetch_addr += 4.
  - DRAIN: imem_req = 0. Every imem_rvalid is dropped and decrements kill. When kill reaches 0, go to FETCH.
- Kept response in FETCH: push {resp_pc, imem_rdata} and add 4 to resp_pc.
- Address arithmetic is modulo 2^32: 32'hFFFF_FFFC + 4 = 0.
- Redirect, from any state:
  - fetch_addr and resp_pc load pc_in; the queue empties (occ = 0).
  - kill = outst + (grant this cycle) − (rvalid this cycle).
  - Go to DRAIN if kill > 0, otherwise to FETCH.
  - A pop in the same cycle is discarded.
  - A response arriving in the same cycle is dropped.
- Pop and push in the same cycle leave occ unchanged. A push into a full queue cannot occur because of the credit rule.
- imem_addr = fetch_addr whenever imem_req = 1.

## Timing
- Reset values:
  - imem_req = 0, inst_valid = 0, fetch_err = 0
  - inst_pc = 0, inst_data = 0
  - fetch_addr = resp_pc = RESET_PC
  - occ = outst = kill = 0; state FETCH
- imem_req first asserts in the cycle after reset deasserts.
- Latency: a response in cycle N makes inst_valid visible in cycle N+1.
- Redirect in cycle N:
  - inst_valid = 0 from N+1.
  - The first request to pc_in is issued in N+1 if kill = 0, otherwise in the cycle after the last stale response.
- Reset asserted mid-operation: all in-flight responses are forgotten. The environment must not return responses across reset.
- Throughput: one instruction per cycle once the queue is primed, provided memory grants every cycle.

## Configuration
- FETCH_ALIGN_CHK_EN defined:
  - A redirect with pc_in[1:0] != 2'b00 sets fetch_err (registered, sticky) and holds imem_req = 0.
  - An aligned redirect clears fetch_err and resumes fetching.
- FETCH_ALIGN_CHK_EN undefined: fetch_err is tied to 0 and pc_in[1:0] is ignored (treated as 0).

## Structure
- Shared package pc_fetch_pkg:
  - RESET_PC default
  - FSM state enum {FETCH, DRAIN}
  - queue entry struct {pc[31:0], data[31:0]}
- One sub-module: fetch_fifo, a synchronous FIFO of DEPTH entries with push/pop/flush and an occupancy output. The top level holds the FSM, counters and address registers.

## Test plan
- Reset, memory grants every cycle with 1-cycle response, inst_ready = 1:
  - requests to 0, 4, 8, …
  - inst_pc sequence 0, 4, 8, … with inst_data matching memory contents
  - one instruction per cycle
- inst_ready = 0, DEPTH = 4, memory always granting:
  - exactly 4 grants, then imem_req = 0, occ = 4
  - one pop re-enables one request
- Redirect to 32'h100 with 3 requests outstanding (3-cycle memory latency):
  - the 3 stale responses are dropped; no request is issued during DRAIN
  - first new request is to 32'h100, first inst_pc = 32'h100
- Redirect coinciding with a grant and a response in the same cycle: kill = outst + 1 − 1, and no stale word reaches the queue.
- Redirect to 32'hFFFF_FFF8: requests go to FFFF_FFF8, FFFF_FFFC, then 0000_0000.
- With FETCH_ALIGN_CHK_EN, redirect to 32'h102:
  - fetch_err = 1 next cycle and imem_req = 0
  - a later redirect to 32'h200 clears fetch_err and fetching resumes
